// File: rtl/stream_demux_1xn_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Select width for a channel count; never returns 0 so a 1-bit select always exists.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_1xn_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_slot #(
  parameter int unsigned DW = 8
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] q,
  output logic          free
);

  // A slot being drained this cycle can take a new beat in the same cycle.
  assign free = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux: explicit-select or round-robin routing into per-channel slots.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = clog2(N),
  parameter int unsigned CNT_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [N*DW-1:0]   out_data,
  output logic [SEL_W-1:0]  cur_ptr,
  output logic              sel_err,
  output logic [CNT_W-1:0]  accept_cnt
);

  localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(N - 1);

  logic [N-1:0]     slot_free;
  logic [N-1:0]     slot_load;
  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             tgt_free;
  logic             xfer;

  assign tgt    = (mode == MODE_RR) ? cur_ptr : in_sel;
  assign tgt_ok = ({1'b0, tgt} < N_LIM);

  always_comb begin
    tgt_free = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = slot_free[k];
    end
  end

  // Out-of-range targets are always accepted so the beat can be discarded.
  assign in_ready = rst_n & enable & (~tgt_ok | tgt_free);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    slot_load = '0;
    for (int unsigned k = 0; k < N; k++) begin
      slot_load[k] = xfer & tgt_ok & (tgt == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load[k]),
      .d     (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .q     (out_data[k*DW +: DW]),
      .free  (slot_free[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ptr    <= '0;
      sel_err    <= 1'b0;
      accept_cnt <= '0;
    end else begin
      sel_err <= xfer & ~tgt_ok;
      if (xfer & tgt_ok) accept_cnt <= accept_cnt + CNT_W'(1);
      if (xfer && (mode == MODE_RR)) cur_ptr <= (cur_ptr == PTR_MAX) ? '0 : cur_ptr + SEL_W'(1);
    end
  end

endmodule
